// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 key tracker.
// - Scancode constants for the prefixes and the controller replies.
// - Event record {ext, rel, code} and its bit offsets (10 bits).
// - Frame receiver state encoding and byte classification helpers.
package ps2_key_tracker_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int unsigned EV_CODE_LSB = 0;
  localparam int unsigned EV_REL_BIT  = 8;
  localparam int unsigned EV_EXT_BIT  = 9;
  localparam int unsigned EV_W        = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Controller replies that carry no key information.
  function automatic logic is_ignored(input logic [7:0] c);
    return (c == PS2_ACK) || (c == PS2_BAT) || (c == PS2_ECHO) || (c == PS2_RESEND);
  endfunction

  // Keyboard-side buffer overrun codes.
  function automatic logic is_overrun(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver in the system clock domain.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   i_ps2_clk       raw PS2C (asynchronous)
//   i_ps2_data      raw PS2D (asynchronous)
//   o_byte          last good received byte
//   o_byte_valid    1-cycle pulse, o_byte is new
//   o_err           1-cycle pulse on bad start/parity/stop or mid-frame timeout
module ps2_frame_rx
  import ps2_key_tracker_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tmo;
  rx_state_t     r_state, w_state_nxt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par_ok;
  logic          w_flip, w_strobe, w_err, w_done;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock follows the synchronised one only after it has
  // disagreed for FILTER_LEN consecutive cycles.
  assign w_flip   = (r_clk_s2 != r_clk_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_strobe = w_flip && r_clk_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_fcnt     <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_fcnt <= '0;
    end else if (w_flip) begin
      r_clk_filt <= r_clk_s2;
      r_fcnt     <= '0;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_strobe || (r_state == RX_IDLE)) begin
      r_tmo <= '0;
    end else if (r_tmo != TW'(TIMEOUT_CYC)) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_done      = 1'b0;
    if ((r_state != RX_IDLE) && (r_tmo == TW'(TIMEOUT_CYC))) begin
      w_state_nxt = RX_IDLE;
      w_err       = 1'b1;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE: begin
          if (r_dat_s2) w_err = 1'b1;
          else          w_state_nxt = RX_DATA;
        end
        RX_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = RX_PARITY;
        RX_PARITY: w_state_nxt = RX_STOP;
        RX_STOP: begin
          w_state_nxt = RX_IDLE;
          if (r_dat_s2 && r_par_ok) w_done = 1'b1;
          else                      w_err  = 1'b1;
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_byte_valid <= w_done;
      o_err        <= w_err;
      if (w_done) o_byte <= r_shift;
      if (w_strobe) begin
        case (r_state)
          RX_IDLE: r_bitcnt <= '0;
          RX_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          // Odd parity: data plus parity bit must hold an odd number of ones.
          RX_PARITY: r_par_ok <= ^{r_shift, r_dat_s2};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, E0/F0 prefix decoder, held-key
// table and event FIFO for the game controls.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   ps2_clk, ps2_data      raw PS/2 lines
//   ev_valid/ev_ready      FIFO head handshake; pop on valid & ready
//   ev_code/ev_ext/ev_release  head event fields
//   held_codes             {ext,code} per slot, slot 0 (LSBs) = oldest
//   held_count             number of valid table slots
//   frame_err              pulse: receive error or keyboard overrun code
//   overflow               pulse: event dropped (FIFO full) or table full on a make
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned MAX_KEYS    = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [7:0]              ev_code,
  output logic                    ev_ext,
  output logic                    ev_release,
  output logic [9*MAX_KEYS-1:0]   held_codes,
  output logic [3:0]              held_count,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid, w_rx_err;

  logic        r_ext, r_brk, r_dv;
  ps2_event_t  r_ev;
  logic        r_frame_err, r_overflow;

  logic [8:0]  r_tab [MAX_KEYS];
  logic [8:0]  w_tab_nxt [MAX_KEYS];
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [8:0]  w_key;
  logic        w_hit, w_full, w_append, w_remove, w_tab_ovf;
  int unsigned w_hit_idx;

  ps2_event_t  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_fcnt;
  logic        w_push, w_pop, w_wr, w_fifo_full, w_drop;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_rx_valid),
    .o_err        (w_rx_err)
  );

  // Prefix decoder: registers one candidate event per good byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_dv        <= 1'b0;
      r_ev        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= w_rx_err | (w_rx_valid & is_overrun(w_rx_byte));
      if (w_rx_valid) begin
        if (w_rx_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_rx_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else if (is_overrun(w_rx_byte)) begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else if (!is_ignored(w_rx_byte)) begin
          r_dv  <= 1'b1;
          r_ev  <= '{ext: r_ext, rel: r_brk, code: w_rx_byte};
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign w_key  = {r_ev.ext, r_ev.code};
  assign w_full = (r_cnt == 4'(MAX_KEYS));

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      if ((i < 32'(r_cnt)) && (r_tab[i] == w_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = i;
      end
    end
  end

  // A make of a key already held is a typematic repeat and is swallowed.
  assign w_append  = r_dv && !r_ev.rel && !w_hit && !w_full;
  assign w_remove  = r_dv &&  r_ev.rel &&  w_hit;
  assign w_tab_ovf = r_dv && !r_ev.rel && !w_hit &&  w_full;
  assign w_push    = r_dv && !(!r_ev.rel && w_hit);

  // Removal compacts the table so slot order stays oldest-first.
  always_comb begin
    w_tab_nxt = r_tab;
    w_cnt_nxt = r_cnt;
    if (w_append) begin
      for (int unsigned i = 0; i < MAX_KEYS; i++) begin
        if (i == 32'(r_cnt)) w_tab_nxt[i] = w_key;
      end
      w_cnt_nxt = r_cnt + 4'd1;
    end else if (w_remove) begin
      for (int unsigned i = 0; i + 1 < MAX_KEYS; i++) begin
        if (i >= w_hit_idx) w_tab_nxt[i] = r_tab[i+1];
      end
      w_tab_nxt[MAX_KEYS-1] = '0;
      w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_KEYS; i++) r_tab[i] <= '0;
      r_cnt <= '0;
    end else begin
      r_tab <= w_tab_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    held_codes = '0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) held_codes[9*i +: 9] = r_tab[i];
  end
  assign held_count = r_cnt;

  // FIFO: a write into a full FIFO is accepted when the head leaves the same cycle.
  assign ev_valid    = (r_fcnt != '0);
  assign w_pop       = ev_valid && ev_ready;
  assign w_fifo_full = (r_fcnt == (PW+1)'(FIFO_DEPTH));
  assign w_wr        = w_push && (!w_fifo_full || w_pop);
  assign w_drop      = w_push && w_fifo_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_ev;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_fcnt     <= r_fcnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
      r_overflow <= w_drop | w_tab_ovf;
    end
  end

  assign ev_code    = r_mem[r_rp].code;
  assign ev_ext     = r_mem[r_rp].ext;
  assign ev_release = r_mem[r_rp].rel;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: drives PS/2 frames and compares against a
// queue-based model of held keys, emitted events and error/overflow pulses.
module tb_ps2_key_tracker;

  localparam int unsigned MAX_KEYS    = 4;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned TIMEOUT_CYC = 5000;
  localparam int unsigned HALF        = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ev_ready = 1'b1;
  logic ev_valid, ev_ext, ev_release, frame_err, overflow;
  logic [7:0] ev_code;
  logic [9*MAX_KEYS-1:0] held_codes;
  logic [3:0] held_count;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_KEYS    (MAX_KEYS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .held_codes (held_codes),
    .held_count (held_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  // Observed side: pulse counts and consumed events.
  int mon_ferr = 0;
  int mon_ovf  = 0;
  logic [9:0] cap_q[$];

  always @(negedge clk) begin
    if (frame_err) mon_ferr++;
    if (overflow)  mon_ovf++;
    if (ev_valid && ev_ready) cap_q.push_back({ev_ext, ev_release, ev_code});
  end

  // Reference model state.
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [8:0] m_held[$];
  logic [9:0] m_exp[$];
  int         m_err = 0;
  int         m_ovf = 0;
  int         m_pend = 0;
  int         m_chk = 0;
  logic       stalled = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*MAX_KEYS-1:0] exp_held();
    logic [9*MAX_KEYS-1:0] v = '0;
    foreach (m_held[i]) v[9*i +: 9] = m_held[i];
    return v;
  endfunction

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic badpar);
    logic p;
    p = ~(^b) ^ badpar;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic emit(input logic [9:0] e, input logic tab_ovf);
    logic drop;
    drop = stalled && (m_pend == FIFO_DEPTH);
    if (!drop) begin
      m_exp.push_back(e);
      if (stalled) m_pend++;
    end
    if (drop || tab_ovf) m_ovf++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] key;
    int idx;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
      idx = 0;
    end else begin
      key = {m_ext, b};
      idx = -1;
      foreach (m_held[i]) if (m_held[i] == key) idx = i;
      if (m_brk) begin
        emit({m_ext, 1'b1, b}, 1'b0);
        if (idx >= 0) m_held.delete(idx);
      end else if (idx < 0) begin
        if (m_held.size() < MAX_KEYS) begin
          m_held.push_back(key);
          emit({m_ext, 1'b0, b}, 1'b0);
        end else begin
          emit({m_ext, 1'b0, b}, 1'b1);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    check({tag, ".held_count"}, held_count, m_held.size());
    check({tag, ".held_codes"}, held_codes, exp_held());
    check({tag, ".frame_err_n"}, mon_ferr, m_err);
    check({tag, ".overflow_n"}, mon_ovf, m_ovf);
    check({tag, ".ev_valid"}, ev_valid, (m_pend != 0));
    n = m_exp.size() - m_pend;
    check({tag, ".events_n"}, cap_q.size(), n);
    while (m_chk < cap_q.size() && m_chk < n) begin
      check($sformatf("%s.event%0d", tag, m_chk), cap_q[m_chk], m_exp[m_chk]);
      m_chk++;
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    send_bits(mkframe(b, 1'b0), 11);
    repeat (HALF) @(posedge clk);
    #1;
    model_byte(b);
    check_all(tag);
  endtask

  task automatic send_badpar(input logic [7:0] b, input string tag);
    send_bits(mkframe(b, 1'b1), 11);
    repeat (HALF) @(posedge clk);
    #1;
    m_err++;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_held.delete();
    m_pend = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ev_valid"}, ev_valid, 0);
    check({tag, ".ev_code"}, ev_code, 0);
    check({tag, ".ev_ext"}, ev_ext, 0);
    check({tag, ".ev_release"}, ev_release, 0);
    check({tag, ".held_codes"}, held_codes, 0);
    check({tag, ".held_count"}, held_count, 0);
    check({tag, ".frame_err"}, frame_err, 0);
    check({tag, ".overflow"}, overflow, 0);
  endtask

  function automatic logic [7:0] pick_key(input int unsigned k);
    case (k)
      0: return 8'h1C;
      1: return 8'h1B;
      2: return 8'h23;
      3: return 8'h2B;
      4: return 8'h34;
      5: return 8'h75;
      default: return 8'h29;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [7:0] b;

    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    // Single make
    send_byte(8'h1C, "make_1C");
    check("make_1C.slot0", held_codes[8:0], 9'h01C);

    // Extended make and release
    send_byte(8'hE0, "ext_pfx");
    send_byte(8'h75, "ext_make_75");
    check("ext_make_75.count", held_count, 2);
    send_byte(8'hE0, "ext_pfx2");
    send_byte(8'hF0, "brk_pfx");
    send_byte(8'h75, "ext_rel_75");
    check("ext_rel_75.count", held_count, 1);

    // Parity error then a good frame
    send_badpar(8'h29, "badpar_29");
    send_byte(8'h29, "good_29");

    // Mid-frame timeout then a good frame
    send_bits(mkframe(8'h1C, 1'b0), 5);
    repeat (TIMEOUT_CYC + 50) @(posedge clk);
    #1;
    m_err++;
    check_all("timeout");
    send_byte(8'hF0, "brk_after_tmo");
    send_byte(8'h1C, "rel_1C_after_tmo");

    // Table fill and overflow, then release from the middle
    do_reset();
    check_reset("reset2");
    send_byte(8'h1C, "fill_1C");
    send_byte(8'h1B, "fill_1B");
    send_byte(8'h23, "fill_23");
    send_byte(8'h2B, "fill_2B");
    send_byte(8'h34, "fill_34_ovf");
    check("fill.count", held_count, 4);
    send_byte(8'hF0, "brk_1B");
    send_byte(8'h1B, "rel_1B");
    check("rel_1B.slots", held_codes, {9'h000, 9'h02B, 9'h023, 9'h01C});

    // FIFO stall: nine distinct makes, then drain
    do_reset();
    @(posedge clk);
    #1 ev_ready = 1'b0;
    stalled = 1'b1;
    send_byte(8'h1C, "stall_1C");
    send_byte(8'h1B, "stall_1B");
    send_byte(8'h23, "stall_23");
    send_byte(8'h2B, "stall_2B");
    send_byte(8'h34, "stall_34");
    send_byte(8'h3B, "stall_3B");
    send_byte(8'h42, "stall_42");
    send_byte(8'h4B, "stall_4B");
    send_byte(8'h4C, "stall_4C");
    check("stall.ev_valid", ev_valid, 1);
    @(posedge clk);
    #1 ev_ready = 1'b1;
    repeat (FIFO_DEPTH + 4) @(posedge clk);
    #1;
    stalled = 1'b0;
    m_pend = 0;
    check_all("drain");
    send_byte(8'h1C, "repeat_1C");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        b = 8'($urandom);
        send_badpar(b, $sformatf("rnd%0d_badpar", i));
      end else begin
        if (r < 12)      b = (r[0]) ? 8'hFF : 8'h00;
        else if (r < 18) b = (r[0]) ? 8'hFA : 8'hAA;
        else if (r < 30) b = 8'hE0;
        else if (r < 50) b = 8'hF0;
        else             b = pick_key($urandom_range(0, 6));
        send_byte(b, $sformatf("rnd%0d_%h", i, b));
      end
    end

    // Reset in the middle of a frame: no error, clean state
    send_bits(mkframe(8'h34, 1'b0), 5);
    do_reset();
    check_reset("midframe_reset");
    check_all("midframe_reset");
    send_byte(8'h1C, "post_reset_1C");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
